img_rsz_seq_mul: RTL and testbench
==================================

# img_rsz_seq_mul

Sequential unsigned shift-and-add multiply-accumulator computing Product = Multiplier × Multiplicand + Addend, one multiplier bit per cycle. It is the inverse of the image resizer's sequential divider: it rebuilds a numerator from quotient, denominator and remainder, and maps output pixel coordinates back through a scale factor. Both sides use a valid/ready handshake, so it drops into the same pipeline slots as the divider.

## Interface
- MULTIPLIER_W, default 8: width of Multiplier (quotient / scale factor); sets the maximum iteration count.
- MULTIPLICAND_W, default 32: width of Multiplicand (denominator / coordinate).
- ADDEND_W, default 32: width of Addend (remainder / offset).
- PRODUCT_W, default 40: width of Product.
- Clk  in  1  clock; all logic is rising-edge.
- Rst  in  1  reset; synchronous, active-high.
- Multiplier  in  MULTIPLIER_W  unsigned; sampled on the accept edge.
- Multiplicand  in  MULTIPLICAND_W  unsigned; sampled on the accept edge.
- Addend  in  ADDEND_W  unsigned; sampled on the accept edge.
- BwVld  in  1  operands valid.
- BwRdy  out  1  block can accept operands.
- Product  out  PRODUCT_W  result; guaranteed only while FwVld=1.
- Overflow  out  1  full result exceeds PRODUCT_W bits; guaranteed only while FwVld=1.
- FwVld  out  1  result valid.
- FwRdy  in  1  downstream accepts the result.

## Operation
- Datapath registers:
  - MplrReg: MULTIPLIER_W bits, shifts right.
  - McandReg: MULTIPLICAND_W+MULTIPLIER_W bits, shifts left.
  - Acc: max(PRODUCT_W, MULTIPLICAND_W+MULTIPLIER_W, ADDEND_W)+1 bits, so no intermediate wrap.
  - Product = Acc[PRODUCT_W-1:0].
  - Overflow = OR of Acc bits at index PRODUCT_W and above.
- FSM states are Idle, Mul, Done. Outputs are Moore-decoded from state: BwRdy=1 only in Idle, FwVld=1 only in Done.
- Idle:
  - On BwVld=1: load MplrReg←Multiplier, McandReg←Multiplicand (zero-extended), Acc←Addend (zero-extended); go to Mul.
  - Otherwise stay in Idle.
- Mul, every cycle:
  - If MplrReg[0]=1, Acc←Acc+McandReg.
  - MplrReg←MplrReg>>1 and McandReg←McandReg<<1.
  - Early exit: if MplrReg>>1 is 0, go to Done; otherwise stay in Mul.
  - Mul always lasts at least one cycle, including when Multiplier=0.
- Done:
  - Acc, Product and Overflow stay stable.
  - On FwRdy=1, go to Idle; otherwise stay in Done.
- No overlap: a new operand set is not accepted until the result has been consumed (BwRdy=0 in Mul and Done).
- Operand inputs are ignored outside the accept edge and may change freely.
- Reset:
  - Rst=1 forces Idle at the next edge from any state and clears Acc, MplrReg and McandReg.
  - An in-flight operation is aborted and its result discarded; FwVld=0 from the cycle after the reset edge.
  - Rst has priority over BwVld and FwRdy on the same edge.
- Reset values of outputs: BwRdy=1, FwVld=0, Product=0, Overflow=0.

## Timing
- Accept edge: rising edge with State=Idle and BwVld=1. BwRdy needs no qualification because it is 1 throughout Idle.
- Mul occupancy: n cycles, where n = max(1, bit index of the MSB set in Multiplier + 1). n ranges from 1 to MULTIPLIER_W.
- FwVld rises exactly n cycles after the accept edge and holds until the edge where FwRdy=1.
- BwRdy returns the cycle after the FwRdy handshake edge.
- Minimum issue interval is n+2 cycles with FwRdy and BwVld held high: n Mul cycles, 1 Done, 1 Idle.
- FwRdy high before Done is ignored. FwRdy low in Done stalls indefinitely with outputs stable.

## Test plan
- Multiplier=5, Multiplicand=1000, Addend=7 -> Product=5007, Overflow=0, FwVld high 3 cycles after accept.
- Multiplier=0, Multiplicand=0xFFFFFFFF, Addend=42 -> Product=42 after 1 Mul cycle.
- Multiplier=255, Multiplicand=0xFFFFFFFF, Addend=0xFFFFFFFF -> Product=0xFFFFFFFF00, Overflow=0, latency 8.
- With PRODUCT_W=36 overridden, operands as in scenario 3 -> Overflow=1, Product=0xFFFFFFF00 (low 36 bits).
- Back-pressure: FwRdy held 0 for 10 cycles in Done -> Product and FwVld stable and BwRdy=0 throughout. Release FwRdy -> BwRdy=1 the next cycle, and the next operand set is accepted correctly.
- Rst pulsed during the 4th Mul cycle of Multiplier=0x80 -> Idle next cycle, FwVld never asserts for the aborted op. A following Multiplier=3, Multiplicand=9, Addend=0 -> Product=27.

Source files
------------

// File: rtl/img_rsz_seq_mul.sv
// Sequential shift-and-add multiply-accumulator: Product = Multiplier * Multiplicand + Addend,
// one multiplier bit per cycle, with valid/ready handshakes on both sides.
module img_rsz_seq_mul #(
    parameter int unsigned MULTIPLIER_W   = 8,
    parameter int unsigned MULTIPLICAND_W = 32,
    parameter int unsigned ADDEND_W       = 32,
    parameter int unsigned PRODUCT_W      = 40
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [MULTIPLIER_W-1:0]   Multiplier,
    input  logic [MULTIPLICAND_W-1:0] Multiplicand,
    input  logic [ADDEND_W-1:0]       Addend,
    input  logic                      BwVld,
    output logic                      BwRdy,
    output logic [PRODUCT_W-1:0]      Product,
    output logic                      Overflow,
    output logic                      FwVld,
    input  logic                      FwRdy
);

    localparam int unsigned MCAND_EXT_W = MULTIPLICAND_W + MULTIPLIER_W;
    localparam int unsigned MAX_A       = (PRODUCT_W > MCAND_EXT_W) ? PRODUCT_W : MCAND_EXT_W;
    localparam int unsigned MAX_B       = (MAX_A > ADDEND_W) ? MAX_A : ADDEND_W;
    // One spare bit above every operand width so the running sum never wraps.
    localparam int unsigned ACC_W       = MAX_B + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [MULTIPLIER_W-1:0]  mplr_reg;
    logic [MCAND_EXT_W-1:0]   mcand_reg;
    logic [ACC_W-1:0]         acc;
    logic                     mul_last;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_last  = ((mplr_reg >> 1) == '0);
        case (state)
            IDLE:    if (BwVld) state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = DONE;
            DONE:    if (FwRdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mplr_reg  <= '0;
            mcand_reg <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (BwVld) begin
                        mplr_reg  <= Multiplier;
                        mcand_reg <= MCAND_EXT_W'(Multiplicand);
                        acc       <= ACC_W'(Addend);
                    end
                end
                MUL: begin
                    if (mplr_reg[0]) begin
                        acc <= acc + ACC_W'(mcand_reg);
                    end
                    mplr_reg  <= mplr_reg >> 1;
                    mcand_reg <= mcand_reg << 1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        BwRdy    = (state == IDLE);
        FwVld    = (state == DONE);
        Product  = acc[PRODUCT_W-1:0];
        Overflow = |acc[ACC_W-1:PRODUCT_W];
    end

endmodule

// File: tb/tb_img_rsz_seq_mul.sv
// Self-checking bench for img_rsz_seq_mul: directed vector table, back-pressure and reset-abort
// sequences, then random operands against an arithmetic reference model (40- and 36-bit products).
module tb_img_rsz_seq_mul;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [7:0]  Multiplier;
    logic [31:0] Multiplicand;
    logic [31:0] Addend;
    logic        BwVld;
    logic        FwRdy;

    logic        BwRdy,  FwVld,  Overflow;
    logic [39:0] Product;
    logic        BwRdy_n, FwVld_n, Overflow_n;
    logic [35:0] Product_n;

    int unsigned checks = 0;
    int unsigned errors = 0;

    img_rsz_seq_mul dut (
        .Clk(Clk), .Rst(Rst),
        .Multiplier(Multiplier), .Multiplicand(Multiplicand), .Addend(Addend),
        .BwVld(BwVld), .BwRdy(BwRdy),
        .Product(Product), .Overflow(Overflow),
        .FwVld(FwVld), .FwRdy(FwRdy)
    );

    img_rsz_seq_mul #(.PRODUCT_W(36)) dut_n (
        .Clk(Clk), .Rst(Rst),
        .Multiplier(Multiplier), .Multiplicand(Multiplicand), .Addend(Addend),
        .BwVld(BwVld), .BwRdy(BwRdy_n),
        .Product(Product_n), .Overflow(Overflow_n),
        .FwVld(FwVld_n), .FwRdy(FwRdy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (errors so far %0d)", errors);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0]  mplr;
        logic [31:0] mcand;
        logic [31:0] add;
        int unsigned lat;
        logic [39:0] p40;
        logic        o40;
        logic [35:0] p36;
        logic        o36;
        int unsigned stall;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_op(input logic [7:0] m, input logic [31:0] mc, input logic [31:0] a,
                         input int unsigned exp_lat,
                         input logic [39:0] ep40, input logic eo40,
                         input logic [35:0] ep36, input logic eo36,
                         input int unsigned stall, input bit early);
        int unsigned w;
        int unsigned lat;
        w = 0;
        while (!BwRdy && w < 20) begin
            cyc();
            w++;
        end
        chk("bwrdy_before_accept", {63'd0, BwRdy}, 64'd1);
        Multiplier   = m;
        Multiplicand = mc;
        Addend       = a;
        BwVld        = 1'b1;
        FwRdy        = early;
        cyc();
        BwVld        = 1'b0;
        Multiplier   = 8'($urandom);
        Multiplicand = $urandom;
        Addend       = $urandom;
        chk("bwrdy_busy", {63'd0, BwRdy}, 64'd0);
        lat = 0;
        while (!FwVld && lat < 20) begin
            cyc();
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("fwvld_36", {63'd0, FwVld_n}, 64'd1);
        chk("product_40", 64'(Product), 64'(ep40));
        chk("overflow_40", {63'd0, Overflow}, {63'd0, eo40});
        chk("product_36", 64'(Product_n), 64'(ep36));
        chk("overflow_36", {63'd0, Overflow_n}, {63'd0, eo36});
        if (!early) begin
            for (int unsigned s = 0; s < stall; s++) begin
                cyc();
                chk("stall_fwvld", {63'd0, FwVld}, 64'd1);
                chk("stall_bwrdy", {63'd0, BwRdy}, 64'd0);
                chk("stall_product", 64'(Product), 64'(ep40));
            end
        end
        FwRdy = 1'b1;
        cyc();
        FwRdy = 1'b0;
        chk("post_hs_fwvld", {63'd0, FwVld}, 64'd0);
        chk("post_hs_bwrdy", {63'd0, BwRdy}, 64'd1);
    endtask

    // Reference: full-precision arithmetic, latency = bits needed to represent the multiplier (min 1).
    task automatic model(input logic [7:0] m, input logic [31:0] mc, input logic [31:0] a,
                         output int unsigned lat, output logic [39:0] p40, output logic o40,
                         output logic [35:0] p36, output logic o36);
        logic [63:0] full;
        full = 64'(m) * 64'(mc) + 64'(a);
        lat  = (m == 0) ? 1 : $clog2(int'(m) + 1);
        p40  = full[39:0];
        o40  = (full >> 40) != 0;
        p36  = full[35:0];
        o36  = (full >> 36) != 0;
    endtask

    initial begin
        bit seen_fwvld;
        vecs[0] = '{8'd5,   32'd1000,       32'd7,          3, 40'd5007,        1'b0, 36'd5007,       1'b0, 0};
        vecs[1] = '{8'd0,   32'hFFFF_FFFF,  32'd42,         1, 40'd42,          1'b0, 36'd42,         1'b0, 0};
        vecs[2] = '{8'd255, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  8, 40'hFF_FFFF_FF00, 1'b0, 36'hF_FFFF_FF00, 1'b1, 0};
        vecs[3] = '{8'd1,   32'd0,          32'd0,          1, 40'd0,           1'b0, 36'd0,          1'b0, 2};
        vecs[4] = '{8'h80,  32'd2,          32'd3,          8, 40'd259,         1'b0, 36'd259,        1'b0, 0};
        vecs[5] = '{8'h0C,  32'h1234_5678,  32'd1,          4, 40'hDA_740D_A1,  1'b0, 36'hDA_740D_A1, 1'b0, 10};
        vecs[6] = '{8'h40,  32'hFFFF_FFFF,  32'd0,          7, 40'h3F_FFFF_FFC0, 1'b0, 36'hF_FFFF_FFC0, 1'b1, 0};

        Rst          = 1'b1;
        BwVld        = 1'b1;
        FwRdy        = 1'b0;
        Multiplier   = 8'hFF;
        Multiplicand = 32'hDEAD_BEEF;
        Addend       = 32'h1234_5678;
        repeat (3) cyc();
        chk("rst_bwrdy", {63'd0, BwRdy}, 64'd1);
        chk("rst_fwvld", {63'd0, FwVld}, 64'd0);
        chk("rst_product", 64'(Product), 64'd0);
        chk("rst_overflow", {63'd0, Overflow}, 64'd0);
        chk("rst_product_36", 64'(Product_n), 64'd0);
        Rst   = 1'b0;
        BwVld = 1'b0;
        cyc();

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].mplr, vecs[i].mcand, vecs[i].add, vecs[i].lat,
                  vecs[i].p40, vecs[i].o40, vecs[i].p36, vecs[i].o36, vecs[i].stall, 1'b0);
        end

        // Early FwRdy during Mul must not shortcut the operation.
        do_op(8'd5, 32'd1000, 32'd7, 3, 40'd5007, 1'b0, 36'd5007, 1'b0, 0, 1'b1);

        // Reset abort in the 4th Mul cycle of a long operation.
        Multiplier   = 8'h80;
        Multiplicand = 32'd77;
        Addend       = 32'd5;
        BwVld        = 1'b1;
        cyc();
        BwVld = 1'b0;
        repeat (3) cyc();
        Rst   = 1'b1;
        FwRdy = 1'b1;
        cyc();
        Rst   = 1'b0;
        FwRdy = 1'b0;
        chk("abort_bwrdy", {63'd0, BwRdy}, 64'd1);
        chk("abort_fwvld", {63'd0, FwVld}, 64'd0);
        chk("abort_product", 64'(Product), 64'd0);
        seen_fwvld = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (FwVld || FwVld_n) seen_fwvld = 1'b1;
        end
        chk("abort_no_fwvld", {63'd0, seen_fwvld}, 64'd0);
        do_op(8'd3, 32'd9, 32'd0, 2, 40'd27, 1'b0, 36'd27, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0]  m;
            logic [31:0] mc, a;
            int unsigned lat;
            logic [39:0] p40;
            logic [35:0] p36;
            logic        o40, o36;
            m  = (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            mc = $urandom;
            a  = $urandom;
            model(m, mc, a, lat, p40, o40, p36, o36);
            do_op(m, mc, a, lat, p40, o40, p36, o36, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
